// File: rtl/aire_panel_tx.sv
// aire_panel_tx: drives an AC panel's power line and four button
// pulse lines so that its speed and setting reach a requested target.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready    command handshake (accept on valid & ready)
//   req_on, req_vel,       requested power, speed code (00 treated as 01)
//   req_set                and setting index 0..3
//   on                     power level, held from acceptance
//   pb1..pb4               speed up/down, setting up/down pulses
//   busy, done             command in progress / one-cycle completion
//   cur_vel, cur_set       shadow copies of the AC speed and setting

module aire_panel_tx #(
  parameter int PRESS_CYCLES = 1,
  parameter int GAP_CYCLES   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_on,
  input  logic [1:0] req_vel,
  input  logic [1:0] req_set,
  output logic       on,
  output logic       pb1,
  output logic       pb2,
  output logic       pb3,
  output logic       pb4,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_vel,
  output logic [1:0] cur_set
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRESS = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] PRESS_LAST = 4'(PRESS_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  logic [2:0] state;
  logic [3:0] tmr;
  logic [1:0] vel_cnt;
  logic [1:0] set_cnt;
  logic       vel_up;
  logic       set_up;

  // Load: press counts are computed combinationally from the request
  // and the shadows so the first pulse can start right after acceptance.
  logic [1:0] tgt_vel;
  logic [1:0] set_diff;
  logic [1:0] ld_vel_cnt;
  logic [1:0] ld_set_cnt;
  logic       ld_vel_up;
  logic       ld_set_up;
  logic       ld_any;

  always_comb begin
    tgt_vel    = (req_vel == 2'd0) ? 2'd1 : req_vel;
    set_diff   = req_set - cur_set;
    ld_vel_up  = tgt_vel > cur_vel;
    ld_set_up  = set_diff != 2'd3;
    ld_vel_cnt = ld_vel_up ? (tgt_vel - cur_vel)
                           : (cur_vel - tgt_vel);
    ld_set_cnt = (set_diff == 2'd3) ? 2'd1 : set_diff;
    if (!req_on) begin
      ld_vel_cnt = 2'd0;
      ld_set_cnt = 2'd0;
    end
    ld_any = (ld_vel_cnt != 2'd0) || (ld_set_cnt != 2'd0);
  end

  // Speed pulses drain first; a pulse is a setting pulse only once
  // the speed count has reached zero.
  logic spd_act;
  logic press;
  logic more;

  assign spd_act = vel_cnt != 2'd0;
  assign press   = state == S_PRESS;
  assign more    = (vel_cnt != 2'd0) || (set_cnt != 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      tmr     <= 4'd0;
      vel_cnt <= 2'd0;
      set_cnt <= 2'd0;
      vel_up  <= 1'b0;
      set_up  <= 1'b0;
      on      <= 1'b0;
      cur_vel <= 2'd1;
      cur_set <= 2'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            on      <= req_on;
            vel_cnt <= ld_vel_cnt;
            set_cnt <= ld_set_cnt;
            vel_up  <= ld_vel_up;
            set_up  <= ld_set_up;
            tmr     <= 4'd0;
            state   <= ld_any ? S_PRESS : S_DONE;
          end
        end
        S_PRESS: begin
          if (tmr == PRESS_LAST) begin
            tmr   <= 4'd0;
            state <= S_GAP;
            if (spd_act) begin
              vel_cnt <= vel_cnt - 2'd1;
              if (vel_up) begin
                if (cur_vel != 2'd3) cur_vel <= cur_vel + 2'd1;
              end else begin
                if (cur_vel != 2'd1) cur_vel <= cur_vel - 2'd1;
              end
            end else begin
              set_cnt <= set_cnt - 2'd1;
              cur_set <= set_up ? cur_set + 2'd1
                                : cur_set - 2'd1;
            end
          end else begin
            tmr <= tmr + 4'd1;
          end
        end
        S_GAP: begin
          if (tmr == GAP_LAST) begin
            tmr   <= 4'd0;
            state <= more ? S_PRESS : S_DONE;
          end else begin
            tmr <= tmr + 4'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pb1       = press &  spd_act &  vel_up;
  assign pb2       = press &  spd_act & ~vel_up;
  assign pb3       = press & ~spd_act &  set_up;
  assign pb4       = press & ~spd_act & ~set_up;
  assign busy      = state != S_IDLE;
  assign req_ready = ~busy;
  assign done      = state == S_DONE;

endmodule
